// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a framed image byte by byte,
// writes each 32-bit word to instruction memory and releases the core once the checksum matches.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_r, state_s;
  logic [15:0] len_r, len_s;
  logic [15:0] word_idx_r, word_idx_s;
  logic [1:0]  byte_cnt_r, byte_cnt_s;
  logic [31:0] asm_r, asm_s;
  logic [7:0]  csum_r, csum_s;
  logic [31:0] addr_s, wdata_s;
  logic        rx_ready_r, mem_we_r, core_rst_r, done_r, err_r;
  logic [31:0] mem_addr_r, mem_wdata_r;
  logic        xfer_s;
  logic [15:0] len_full_s;

  assign xfer_s     = rx_valid & rx_ready_r;
  assign len_full_s = {rx_data, len_r[7:0]};

  // Next-state and datapath update for the frame parser
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    word_idx_s = word_idx_r;
    byte_cnt_s = byte_cnt_r;
    asm_s      = asm_r;
    csum_s     = csum_r;
    addr_s     = mem_addr_r;
    wdata_s    = mem_wdata_r;
    case (state_r)
      IDLE: begin
        csum_s     = 8'h00;
        word_idx_s = 16'd0;
        byte_cnt_s = 2'd0;
        if (xfer_s && (rx_data == 8'hA5)) begin
          state_s = LEN_LO;
        end else begin
          state_s = IDLE;
        end
      end
      LEN_LO: begin
        if (xfer_s) begin
          len_s   = {8'h00, rx_data};
          state_s = LEN_HI;
        end else begin
          state_s = LEN_LO;
        end
      end
      LEN_HI: begin
        if (xfer_s) begin
          len_s = len_full_s;
          if (len_full_s == 16'd0) begin
            state_s = CSUM;
          end else if ({1'b0, len_full_s} > MAX_LEN) begin
            state_s = ERR;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = LEN_HI;
        end
      end
      DATA: begin
        if (xfer_s) begin
          // Shifting in from the top leaves the first byte in [7:0] after four bytes
          asm_s  = {rx_data, asm_r[31:8]};
          csum_s = csum_r + rx_data;
          if (byte_cnt_r == 2'd3) begin
            byte_cnt_s = 2'd0;
            addr_s     = BASE_ADDR + {14'd0, word_idx_r, 2'b00};
            wdata_s    = {rx_data, asm_r[31:8]};
            state_s    = WRITE;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
            state_s    = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      WRITE: begin
        word_idx_s = word_idx_r + 16'd1;
        if ((word_idx_r + 16'd1) < len_r) begin
          state_s = DATA;
        end else begin
          state_s = CSUM;
        end
      end
      CSUM: begin
        if (xfer_s) begin
          if (rx_data == csum_r) begin
            state_s = DONE;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = CSUM;
        end
      end
      DONE:    state_s = DONE;
      ERR:     state_s = ERR;
      default: state_s = IDLE;
    endcase
  end

  // State, counters and output registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= 16'd0;
      word_idx_r  <= 16'd0;
      byte_cnt_r  <= 2'd0;
      asm_r       <= 32'd0;
      csum_r      <= 8'h00;
      rx_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      core_rst_r  <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      word_idx_r  <= word_idx_s;
      byte_cnt_r  <= byte_cnt_s;
      asm_r       <= asm_s;
      csum_r      <= csum_s;
      rx_ready_r  <= (state_s == IDLE) || (state_s == LEN_LO) || (state_s == LEN_HI) ||
                     (state_s == DATA) || (state_s == CSUM);
      mem_we_r    <= (state_s == WRITE);
      mem_addr_r  <= addr_s;
      mem_wdata_r <= wdata_s;
      core_rst_r  <= (state_s != DONE);
      done_r      <= (state_s == DONE);
      err_r       <= (state_s == ERR);
    end
  end

  // A reset landing on the edge that ends WRITE must not commit that word
  assign mem_we    = mem_we_r & ~rst;
  assign rx_ready  = rx_ready_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign core_rst  = core_rst_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed frame tests for imem_loader, checked against a
// frame-level parsing model of the loader protocol.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          MAXW = 4;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, core_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  int exp_acc, exp_res;  // exp_res: 0 frame incomplete, 1 done, 2 err

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Capture writes and check per-cycle output invariants
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
      check_eq("ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
    check_eq("done_err_excl", {31'd0, done & err}, 32'd0);
    check_eq("core_rst_inv", {31'd0, core_rst}, {31'd0, ~done});
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_a.delete();
    got_d.delete();
    check_eq("rst_ready", {31'd0, rx_ready}, 32'd1);
    check_eq("rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_core", {31'd0, core_rst}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
  endtask

  // Offer one byte (called at a negedge); gives up after a bounded wait
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level expectation: locate magic, decode length, slice payload into words
  task automatic model(input byte_q_t b);
    int m, len, n, avail, take;
    logic [7:0] cs;
    exp_a.delete();
    exp_d.delete();
    exp_res = 0;
    m = 0;
    while (m < b.size() && b[m] != 8'hA5) m++;
    if (m + 2 >= b.size()) begin
      exp_acc = b.size();
      return;
    end
    len = int'(b[m+1]) + 256 * int'(b[m+2]);
    if (len > MAXW) begin
      exp_acc = m + 3;
      exp_res = 2;
      return;
    end
    n = 4 * len;
    avail = b.size() - (m + 3);
    take = (avail < n) ? avail : n;
    cs = 8'h00;
    for (int k = 0; k < take; k++) cs = cs + b[m+3+k];
    for (int w = 0; w < take / 4; w++) begin
      exp_a.push_back(BASE + 32'(4 * w));
      exp_d.push_back({b[m+3+4*w+3], b[m+3+4*w+2], b[m+3+4*w+1], b[m+3+4*w]});
    end
    if (avail <= n) begin
      exp_acc = b.size();
      return;
    end
    exp_acc = m + 3 + n + 1;
    exp_res = (b[m+3+n] == cs) ? 1 : 2;
  endtask

  // Drive a byte list (gap < 0: random gaps) and compare against the model
  task automatic run_frame(input string name, input byte_q_t b, input int gap);
    int acc, g, nw;
    bit ok;
    acc = 0;
    for (int i = 0; i < b.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_byte(b[i], g, ok);
      if (!ok) break;
      acc++;
    end
    repeat (3) @(negedge clk);
    model(b);
    check_eq({name, "_accepted"}, 32'(acc), 32'(exp_acc));
    check_eq({name, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    nw = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < nw; i++) begin
      check_eq({name, "_addr"}, got_a[i], exp_a[i]);
      check_eq({name, "_data"}, got_d[i], exp_d[i]);
    end
    check_eq({name, "_done"}, {31'd0, done}, {31'd0, exp_res == 1});
    check_eq({name, "_err"}, {31'd0, err}, {31'd0, exp_res == 2});
    check_eq({name, "_core_rst"}, {31'd0, core_rst}, {31'd0, exp_res != 1});
    check_eq({name, "_ready"}, {31'd0, rx_ready}, {31'd0, exp_res == 0});
    check_eq({name, "_we_idle"}, {31'd0, mem_we}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t f;
    logic [7:0] cs, v;
    int len, nj;
    bit ok;

    do_reset();
    f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
    run_frame("one_word", f, 0);
    if (got_d.size() > 0) check_eq("one_word_lit", got_d[0], 32'h0000_0513);

    do_reset();
    f = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    cs = 8'h00;
    for (int i = 3; i < f.size(); i++) cs = cs + f[i];
    f.push_back(cs);
    run_frame("two_gap", f, 1);

    do_reset();
    f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("zero_len", f, 0);

    do_reset();
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame("bad_csum", f, 0);

    do_reset();
    f = '{8'hA5, 8'h05, 8'h00, 8'h12};
    run_frame("too_long", f, 0);

    do_reset();
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < f.size(); i++) send_byte(f[i], 0, ok);
    repeat (2) @(negedge clk);
    check_eq("abort_nowrite", 32'(got_a.size()), 32'd0);
    do_reset();
    f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
    run_frame("after_abort", f, 0);

    for (int t = 0; t < 40; t++) begin
      do_reset();
      f.delete();
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        do v = 8'($urandom); while (v == 8'hA5);
        f.push_back(v);
      end
      f.push_back(8'hA5);
      len = $urandom_range(0, 6);
      f.push_back(8'(len));
      f.push_back(($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
      cs = 8'h00;
      for (int j = 0; j < 4 * ((len > MAXW) ? 1 : len); j++) begin
        v = 8'($urandom);
        cs = cs + v;
        f.push_back(v);
      end
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'h5A;
      f.push_back(cs);
      run_frame("rand", f, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, the largest accepted image length in words (range 1..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_valid  input  1  the byte source offers rx_data.
REQ-006 SHALL have port rx_data  input  8  the offered byte.
REQ-007 SHALL have port rx_ready  output  1  the loader accepts the byte; a transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-008 SHALL have port mem_we  output  1  single-cycle write strobe to instruction memory.
REQ-009 SHALL have port mem_addr  output  32  byte address of the write, always word-aligned.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port core_rst  output  1  holds the core in reset until the image is loaded.
REQ-012 SHALL have port done  output  1  image loaded and checksum verified.
REQ-013 SHALL have port err  output  1  load aborted (length or checksum fault).

Function
REQ-014 SHALL accept the frame format: magic 0xA5, LEN_LO, LEN_HI (LEN = image words, little-endian), LEN*4 payload bytes, then 1 checksum byte.
REQ-015 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
REQ-016 IDLE: accepted byte 0xA5 -> LEN_LO; any other accepted byte is discarded and the state stays IDLE.
REQ-017 LEN_LO -> LEN_HI on the accepted byte; LEN_HI -> DATA if 1 <= LEN <= MAX_WORDS, -> CSUM if LEN == 0, -> ERR if LEN > MAX_WORDS.
REQ-018 DATA: accepted bytes assemble little-endian (first byte -> wdata[7:0], fourth -> [31:24]); after the fourth byte -> WRITE.
REQ-019 WRITE lasts exactly one cycle: mem_we=1, mem_addr=BASE_ADDR+4*word_index, mem_wdata=assembled word; rx_ready=0; then word_index increments and the state -> DATA if words remain, else -> CSUM.
REQ-020 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-021 The running checksum SHALL be the 8-bit modulo-256 sum of payload bytes only (not magic, not length); it is cleared in IDLE.
REQ-022 CSUM: the accepted byte equal to the running checksum -> DONE; otherwise -> ERR.
REQ-023 rx_ready SHALL be 1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM and 0 in WRITE, DONE, ERR.
REQ-024 DONE: done=1, core_rst=0, no further bytes accepted; held until rst.
REQ-025 ERR: err=1, core_rst=1, no further bytes accepted; held until rst.
REQ-026 done and err SHALL never be 1 simultaneously.
REQ-027 core_rst SHALL be 1 in every state except DONE.
REQ-028 No gap limit: rx_valid may drop for any number of cycles between bytes without affecting state.
REQ-029 Byte offset and word_index counters SHALL wrap only by completing a word or an image; word_index never exceeds LEN.

Reset
REQ-030 While rst is high on a rising edge, the state SHALL go to IDLE and the counters and checksum SHALL clear. The cycle after reset, outputs SHALL be rx_ready=1, mem_we=0, core_rst=1, done=0, err=0, mem_addr=0, mem_wdata=0.
REQ-031 rst asserted mid-frame, including in WRITE, SHALL abort the frame with no write issued on that edge; previously written words remain in memory.
REQ-032 rst SHALL be the only exit from DONE and ERR.

Verification
REQ-033 Send A5 01 00 13 05 00 00 18 -> one mem_we pulse with addr 0x0, wdata 0x00000513; then done=1, core_rst=0.
REQ-034 Send A5 02 00, 8 bytes with 1-cycle rx_valid gaps, then the correct checksum -> writes to 0x0 and 0x4, rx_ready=0 exactly during each WRITE cycle, done=1.
REQ-035 Send 00 FF A5 00 00 00 -> leading bytes ignored, zero-length image, no writes, done=1.
REQ-036 Send A5 01 00 11 22 33 44 00 -> one write of 0x44332211, then err=1, core_rst=1, done=0, rx_ready=0.
REQ-037 MAX_WORDS=4, send A5 05 00 -> err=1 after LEN_HI, no mem_we.
REQ-038 Assert rst after 2 payload bytes, then send a valid 1-word frame -> the first frame causes no write, the second writes its word to BASE_ADDR and done=1.
